mem_uart_bridge: RTL and testbench

MEM_UART_BRIDGE -- requirements
Module: mem_uart_bridge

---
 rtl/mem_uart_bridge.sv | 159 +++++++++++++++
 tb/tb_mem_uart_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_uart_bridge.sv
// Memory-mapped bridge between a CPU bus and a byte-wide USB serial link.
// A 16-byte register window exposes DATA, STATUS and CTRL; TX and RX bytes
// are buffered in two DEPTH-entry FIFOs. DEPTH must be a power of two, 2..256.
module mem_uart_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FB00,
  parameter int          DEPTH     = 16
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      r_state;
  logic [7:0]  r_wbyte;
  logic [7:0]  r_tx_mem [DEPTH];
  logic [7:0]  r_rx_mem [DEPTH];
  logic [AW:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;

  logic        w_hit, w_idle_hit, w_is_write, w_data_wr;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_clear;
  logic [1:0]  w_off;
  logic [7:0]  w_tx_din, w_rx_head;
  logic [AW:0] w_tx_cnt, w_rx_cnt;
  logic        w_unused;

  // Counts are reported as 8-bit fields, pinned at 255 for DEPTH=256.
  function automatic logic [7:0] sat8(input logic [AW:0] cnt);
    logic [8:0] ext;
    ext = 9'(cnt);
    return ext[8] ? 8'hFF : ext[7:0];
  endfunction

  // Address decode; only a request seen in IDLE is acted on.
  assign w_hit      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = mem_addr[3:2];
  assign w_is_write = |mem_wstrb;
  assign w_idle_hit = (r_state == ST_IDLE) && w_hit;
  assign w_data_wr  = w_idle_hit && (w_off == OFF_DATA) && mem_wstrb[0];
  assign w_clear    = w_idle_hit && (w_off == OFF_CTRL) && mem_wstrb[0] && mem_wdata[0];

  // FIFO status from pointers: equal means empty, MSB-only difference means full.
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
  assign w_rx_full  = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
  assign w_tx_cnt   = r_tx_wr - r_tx_rd;
  assign w_rx_cnt   = r_rx_wr - r_rx_rd;

  // A stalled write pushes the byte latched when it entered WAIT.
  assign w_tx_push = !w_tx_full && (w_data_wr || (r_state == ST_WAIT));
  assign w_tx_din  = (r_state == ST_WAIT) ? r_wbyte : mem_wdata[7:0];
  assign w_tx_pop  = tx_valid && tx_ready && !w_clear;
  assign w_rx_push = rx_valid && rx_ready && !w_clear;
  assign w_rx_pop  = w_idle_hit && (w_off == OFF_DATA) && !w_is_write && !w_rx_empty;

  assign tx_valid  = !w_tx_empty;
  assign tx_data   = r_tx_mem[r_tx_rd[AW-1:0]];
  assign rx_ready  = !w_rx_full;
  assign w_rx_head = r_rx_mem[r_rx_rd[AW-1:0]];

  assign w_unused = &{1'b0, mem_addr[1:0], mem_wdata[31:8]};

  // FIFO storage writes.
  // NOTE: storage arrays carry no reset; the pointers alone define FIFO contents.
  always_ff @(posedge clk_48mhz) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= w_tx_din;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= rx_data;
  end

  // TX pointers: a CTRL clear overrides any pop in the same cycle.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else if (w_clear) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
    end
  end

  // RX pointers: a CTRL clear discards any byte offered in the same cycle.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else if (w_clear) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
    end
  end

  // Bus FSM with registered mem_ready/mem_rdata; RESP always returns to IDLE.
  // NOTE: non-blocking assignments so every decision uses pre-edge register values.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wbyte   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            if (w_data_wr && w_tx_full) begin
              r_state <= ST_WAIT;
              r_wbyte <= mem_wdata[7:0];
            end else begin
              r_state   <= ST_RESP;
              mem_ready <= 1'b1;
              if (!w_is_write) begin
                case (w_off)
                  OFF_DATA:   mem_rdata <= w_rx_empty ? 32'h0 : {23'b0, 1'b1, w_rx_head};
                  OFF_STATUS: mem_rdata <= {16'b0, sat8(w_tx_cnt), sat8(w_rx_cnt)};
                  default:    mem_rdata <= 32'h0;
                endcase
              end
            end
          end
        end
        ST_WAIT: begin
          if (!w_tx_full) begin
            r_state   <= ST_RESP;
            mem_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_uart_bridge.sv
// Randomized self-checking bench for mem_uart_bridge with a queue-based
// reference model of the register window and both FIFOs.
module tb_mem_uart_bridge;

  localparam logic [31:0] BASE     = 32'hFFFF_FB00;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] A_DATA   = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'd4;
  localparam logic [31:0] A_CTRL   = BASE + 32'd8;
  localparam logic [31:0] A_RSVD   = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  mem_uart_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_48mhz (clk),
    .reset     (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  // Reference model: applies one bus access to the queues, returns read data.
  function automatic logic [31:0] model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                               input logic [3:0] wstrb);
    logic [31:0] r;
    r = 32'h0;
    if (wstrb != 4'h0) begin
      if (addr == A_DATA && wstrb[0]) tx_exp.push_back(wdata[7:0]);
      if (addr == A_CTRL && wstrb[0] && wdata[0]) begin
        tx_exp.delete();
        rx_exp.delete();
      end
    end else if (addr == A_DATA) begin
      if (rx_exp.size() > 0) r = 32'h100 | 32'(rx_exp.pop_front());
    end else if (addr == A_STATUS) begin
      r = {16'h0, sat8(tx_exp.size()), sat8(rx_exp.size())};
    end
    return r;
  endfunction

  // TX sink monitor: every byte the DUT hands over must be the model's next byte.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      check("tx_pop_expected", 32'(tx_exp.size() > 0), 32'd1);
      if (tx_exp.size() > 0) check("tx_order", 32'(tx_data), 32'(tx_exp.pop_front()));
    end
  end

  // One bus transaction; optionally offers an RX byte during the first cycle.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic rx_side, input logic [7:0] rx_byte,
                     output logic [31:0] rdata, output int lat);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    rx_valid = rx_side; rx_data = rx_byte;
    lat = 0;
    rdata = '0;
    while (lat < 50) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      lat++;
      if (mem_ready) begin
        rdata = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    check("ready_single_pulse", 32'(mem_ready), 32'd0);
    check("rdata_zero_when_idle", mem_rdata, 32'd0);
  endtask

  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input string tag);
    logic [31:0] exp, rd;
    int lat;
    exp = model_access(addr, wdata, wstrb);
    bus(addr, wdata, wstrb, 1'b0, 8'h00, rd, lat);
    check({tag, "_latency"}, 32'(lat), 32'd1);
    if (wstrb == 4'h0) check({tag, "_rdata"}, rd, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    check("rx_ready_vs_model", 32'(rx_ready), 32'(rx_exp.size() < DEPTH));
    rx_valid = 1'b1; rx_data = b;
    if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    tx_ready = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
  endtask

  task automatic nonhit(input logic [31:0] addr, input logic [3:0] wstrb);
    int seen;
    seen = 0;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = $urandom; mem_wstrb = wstrb;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_ready) seen++;
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    check("nonhit_no_ready", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, stall, got;

    // Reset values, sampled between edges while reset is held.
    #1 rst = 1'b1;
    #4;
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single TX write with the sink ready.
    void'(model_access(A_DATA, 32'h41, 4'h1));
    mem_valid = 1'b1; mem_addr = A_DATA; mem_wdata = 32'h41; mem_wstrb = 4'h1; tx_ready = 1'b1;
    @(posedge clk); #1;
    check("s37_ready", 32'(mem_ready), 32'd1);
    check("s37_tx_valid", 32'(tx_valid), 32'd1);
    check("s37_tx_data", 32'(tx_data), 32'h41);
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    check("s37_ready_pulse", 32'(mem_ready), 32'd0);
    check("s37_popped", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    @(posedge clk); #1;

    // TX back-pressure: the 17th write stalls until one pop frees a slot.
    for (int i = 0; i < DEPTH; i++) access(A_DATA, 32'(i), 4'h1, "s38_fill");
    check("s38_full_valid", 32'(tx_valid), 32'd1);
    void'(model_access(A_DATA, 32'h10, 4'h1));
    mem_valid = 1'b1; mem_addr = A_DATA; mem_wdata = 32'h10; mem_wstrb = 4'h1;
    stall = 0; got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      @(posedge clk); #1;
      if (mem_ready) got = 1;
      else begin
        stall++;
        tx_ready = (stall == 5);
      end
    end
    tx_ready = 1'b0;
    check("s38_released", 32'(got), 32'd1);
    check("s38_stall_cycles", 32'(stall), 32'd6);
    mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); #1;
    drain(DEPTH + 4);
    check("s38_all_out", 32'(tx_exp.size()), 32'd0);
    check("s38_empty", 32'(tx_valid), 32'd0);

    // RX reads: two bytes then an empty read.
    rx_push(8'h55);
    rx_push(8'hAA);
    access(A_DATA, 32'h0, 4'h0, "s39_read0");
    access(A_DATA, 32'h0, 4'h0, "s39_read1");
    access(A_DATA, 32'h0, 4'h0, "s39_read_empty");

    // RX full: back-pressure, STATUS count, and recovery after one read.
    for (int i = 0; i < DEPTH; i++) rx_push(8'(8'h30 + i));
    check("s40_rx_full", 32'(rx_ready), 32'd0);
    rx_push(8'hEE);
    access(A_STATUS, 32'h0, 4'h0, "s40_status");
    access(A_DATA, 32'h0, 4'h0, "s40_read");
    check("s40_rx_ready_back", 32'(rx_ready), 32'd1);

    // CTRL clear with an RX byte offered in the same cycle.
    access(A_DATA, 32'h5A, 4'h1, "s41_tx_byte");
    void'(model_access(A_CTRL, 32'h1, 4'h1));
    bus(A_CTRL, 32'h1, 4'h1, 1'b1, 8'h77, rd, lat);
    check("s41_latency", 32'(lat), 32'd1);
    check("s41_tx_valid", 32'(tx_valid), 32'd0);
    access(A_STATUS, 32'h0, 4'h0, "s41_status");
    access(A_DATA, 32'h0, 4'h0, "s41_rx_discarded");

    // Non-hit addresses and the remaining register offsets.
    for (int k = 0; k < 4; k++) nonhit(A_DATA ^ (32'h10 << (7 * k)), 4'(k));
    access(A_STATUS, 32'hFFFF_FFFF, 4'hF, "status_write");
    access(A_CTRL, 32'h0, 4'h0, "ctrl_read");
    access(A_RSVD, 32'h0, 4'h0, "rsvd_read");
    access(A_RSVD, 32'h1, 4'h1, "rsvd_write");
    access(A_STATUS, 32'h0, 4'h0, "status_after_misc");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0, 1: rx_push(8'($urandom));
        2:    drain($urandom_range(1, 3));
        3: begin
          if (tx_exp.size() < DEPTH) access(A_DATA, $urandom, 4'($urandom_range(1, 15)), "rnd_data_wr");
          else drain(2);
        end
        4: access(A_DATA, 32'h0, 4'h0, "rnd_data_rd");
        5: access(A_STATUS, 32'h0, 4'h0, "rnd_status");
        6: begin
          if ($urandom_range(0, 9) == 0) access(A_CTRL, 32'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), "rnd_ctrl");
          else access(A_RSVD, 32'h0, 4'h0, "rnd_rsvd");
        end
        default: nonhit(BASE + 32'h10 * 32'($urandom_range(1, 100)), 4'($urandom_range(0, 15)));
      endcase
    end

    // Reset in WAIT abandons the stalled write.
    access(A_CTRL, 32'h1, 4'h1, "s42_clear");
    rx_push(8'h12);
    rx_push(8'h34);
    for (int i = 0; i < DEPTH; i++) access(A_DATA, 32'(8'hC0 + i), 4'h1, "s42_fill");
    mem_valid = 1'b1; mem_addr = A_DATA; mem_wdata = 32'h99; mem_wstrb = 4'h1;
    repeat (3) begin
      @(posedge clk); #1;
      check("s42_stalled", 32'(mem_ready), 32'd0);
    end
    #4 rst = 1'b1; mem_valid = 1'b0; mem_wstrb = '0;
    #1;
    check("s42_rst_ready", 32'(mem_ready), 32'd0);
    check("s42_rst_rdata", mem_rdata, 32'd0);
    check("s42_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("s42_rst_rx_ready", 32'(rx_ready), 32'd1);
    tx_exp.delete();
    rx_exp.delete();
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("s42_no_push", 32'(tx_valid), 32'd0);
      check("s42_no_ready", 32'(mem_ready), 32'd0);
    end
    access(A_STATUS, 32'h0, 4'h0, "s42_status");
    access(A_DATA, 32'h0, 4'h0, "s42_rx_empty");

    // Final flush of whatever the model still holds.
    drain(DEPTH + 4);
    check("end_tx_all_out", 32'(tx_exp.size()), 32'd0);
    while (rx_exp.size() > 0) access(A_DATA, 32'h0, 4'h0, "end_rx_flush");
    access(A_DATA, 32'h0, 4'h0, "end_rx_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
